// File: rtl/uart_fifo_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge_if
// Purpose  : Host-side and UART-side handshake signals of the FIFO bridge.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_fifo_bridge_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic [DEPTH_LOG2:0] tx_level;
    logic [DEPTH_LOG2:0] rx_level;
    logic [7:0]          uart_out_data;
    logic                uart_wr;
    logic                uart_tx_empty;
    logic [7:0]          uart_in_data;
    logic                uart_rd;
    logic                uart_rx_empty;

    // The bridge is the slave; the host/UART environment is the master.
    modport slave (
        input  tx_data, tx_valid, rx_ready, uart_tx_empty, uart_in_data, uart_rx_empty,
        output tx_ready, rx_data, rx_valid, tx_level, rx_level, uart_out_data, uart_wr, uart_rd
    );

    modport master (
        output tx_data, tx_valid, rx_ready, uart_tx_empty, uart_in_data, uart_rx_empty,
        input  tx_ready, rx_data, rx_valid, tx_level, rx_level, uart_out_data, uart_wr, uart_rd
    );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_bridge
// Purpose  : TX/RX byte FIFOs between host logic and a byte-level UART core.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    uart_fifo_bridge_if.slave bus
);
    localparam int                    c_DEPTH   = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_LVL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = (DEPTH_LOG2)'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ARM  = 2'd1;
    localparam logic [1:0] c_ST_BUSY = 2'd2;

    logic [7:0]            r_tx_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
    logic [DEPTH_LOG2:0]   r_tx_level;
    logic [7:0]            r_rx_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
    logic [DEPTH_LOG2:0]   r_rx_level;
    logic [1:0]            r_state, w_state_nxt;
    logic [7:0]            r_uart_out_data;
    logic                  r_uart_wr, r_uart_rd, r_rd_guard;
    logic                  w_tx_pop, w_tx_push, w_tx_ready, w_tx_empty, w_tx_full;
    logic                  w_rx_pop, w_rx_push, w_rx_empty, w_rx_full;

    assign w_tx_empty = (r_tx_level == '0);
    assign w_tx_full  = (r_tx_level == c_FULL);
    assign w_rx_empty = (r_rx_level == '0);
    assign w_rx_full  = (r_rx_level == c_FULL);

    // A full TX FIFO still accepts a byte in the cycle the FSM pops its head.
    assign w_tx_ready = !w_tx_full || w_tx_pop;
    assign w_tx_push  = bus.tx_valid && w_tx_ready;
    assign w_rx_pop   = !w_rx_empty && bus.rx_ready;
    assign w_rx_push  = !bus.uart_rx_empty && !r_rd_guard && (!w_rx_full || w_rx_pop);

    // ARM exists because the UART raises busy only one cycle after the load.
    always_comb begin
        w_state_nxt = r_state;
        w_tx_pop    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_tx_empty && bus.uart_tx_empty) begin
                    w_tx_pop    = 1'b1;
                    w_state_nxt = c_ST_ARM;
                end
            end
            c_ST_ARM:  w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: begin
                if (bus.uart_tx_empty) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= bus.tx_data;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= bus.uart_in_data;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_level <= '0;
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_PTR_ONE;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_PTR_ONE;
            if (w_tx_push && !w_tx_pop)      r_tx_level <= r_tx_level + c_LVL_ONE;
            else if (!w_tx_push && w_tx_pop) r_tx_level <= r_tx_level - c_LVL_ONE;
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_PTR_ONE;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_PTR_ONE;
            if (w_rx_push && !w_rx_pop)      r_rx_level <= r_rx_level + c_LVL_ONE;
            else if (!w_rx_push && w_rx_pop) r_rx_level <= r_rx_level - c_LVL_ONE;
        end
    end

    // rd_guard masks the cycle in which the UART's empty flag is still clearing.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_uart_out_data <= 8'h00;
            r_uart_wr       <= 1'b0;
            r_uart_rd       <= 1'b0;
            r_rd_guard      <= 1'b0;
        end else begin
            r_uart_wr  <= w_tx_pop;
            r_uart_rd  <= w_rx_push;
            r_rd_guard <= w_rx_push;
            if (w_tx_pop) begin
                r_uart_out_data <= r_tx_mem[r_tx_rptr];
            end
        end
    end

    assign bus.tx_ready      = w_tx_ready;
    assign bus.rx_valid      = !w_rx_empty;
    assign bus.rx_data       = r_rx_mem[r_rx_rptr];
    assign bus.tx_level      = r_tx_level;
    assign bus.rx_level      = r_rx_level;
    assign bus.uart_out_data = r_uart_out_data;
    assign bus.uart_wr       = r_uart_wr;
    assign bus.uart_rd       = r_uart_rd;
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_fifo_bridge
// Purpose  : Randomized bench for uart_fifo_bridge with queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_bridge;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    uart_fifo_bridge_if #(.DEPTH_LOG2(4)) bus ();
    uart_fifo_bridge #(.DEPTH_LOG2(4)) u_dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: bytes accepted but not yet loaded / captured but not yet read.
    byte unsigned tx_q[$];
    byte unsigned rx_q[$];

    bit         u_busy, u_pend, r_present, r_taken;
    int         u_timer, idle_cnt;
    bit         pend_push, pend_pop, tx_idle_prev;
    logic [7:0] pend_byte, pend_rx_byte, cur_rx, tx_next;
    int         p_tx, p_rx, p_arr, frame_min, frame_max;
    bit         tx_incr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_model();
        tx_q.delete();
        rx_q.delete();
        u_busy = 0; u_pend = 0; u_timer = 0; idle_cnt = 0;
        r_present = 0; r_taken = 0;
        pend_push = 0; pend_pop = 0; tx_idle_prev = 0;
        bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
        bus.uart_tx_empty = 1'b1; bus.uart_rx_empty = 1'b1; bus.uart_in_data = 8'h00;
    endtask

    // One clock: settle effects of the previous edge, drive, then take the edge.
    task automatic step();
        bit exp_rd, cleared;
        @(negedge sys_clk);
        if (bus.uart_wr) begin
            chk("wr_uart_idle", {31'd0, !u_busy && !u_pend}, 32'd1);
            chk("wr_q_nonempty", {31'd0, tx_q.size() != 0}, 32'd1);
            if (tx_q.size() != 0) chk("tx_byte", bus.uart_out_data, tx_q.pop_front());
            idle_cnt = 0;
        end else if (tx_idle_prev) begin
            idle_cnt++;
            chk("tx_gap", {31'd0, idle_cnt <= 1}, 32'd1);
        end else begin
            idle_cnt = 0;
        end
        if (pend_push) tx_q.push_back(pend_byte);
        chk("tx_level", bus.tx_level, tx_q.size());
        if (u_pend) begin
            u_pend = 0; u_busy = 1;
            u_timer = $urandom_range(frame_max, frame_min);
            bus.uart_tx_empty = 1'b0;
        end else if (u_busy) begin
            u_timer--;
            if (u_timer <= 0) begin
                u_busy = 0;
                bus.uart_tx_empty = 1'b1;
            end
        end
        if (bus.uart_wr) u_pend = 1;

        exp_rd = r_present && !r_taken && (rx_q.size() < 16 || pend_pop);
        if (pend_pop && rx_q.size() != 0) chk("rx_byte", pend_rx_byte, rx_q.pop_front());
        chk("uart_rd", bus.uart_rd, exp_rd);
        cleared = 0;
        if (bus.uart_rd && r_present && !r_taken) begin
            rx_q.push_back(cur_rx);
            r_taken = 1;
        end else if (r_taken) begin
            r_taken = 0; r_present = 0; cleared = 1;
            bus.uart_rx_empty = 1'b1;
        end
        chk("rx_level", bus.rx_level, rx_q.size());
        chk("rx_valid", bus.rx_valid, rx_q.size() != 0);
        if (rx_q.size() != 0) chk("rx_head", bus.rx_data, rx_q[0]);
        if (!r_present && !cleared && $urandom_range(99) < p_arr) begin
            cur_rx = 8'($urandom);
            bus.uart_in_data = cur_rx;
            bus.uart_rx_empty = 1'b0;
            r_present = 1;
        end

        bus.tx_valid = ($urandom_range(99) < p_tx);
        bus.tx_data  = tx_incr ? tx_next : 8'($urandom);
        bus.rx_ready = ($urandom_range(99) < p_rx);
        #1;
        if (tx_q.size() < 16) chk("tx_ready", bus.tx_ready, 1);
        else if (u_busy || u_pend) chk("tx_ready_full", bus.tx_ready, 0);
        pend_push = bus.tx_valid && bus.tx_ready;
        pend_byte = bus.tx_data;
        if (pend_push && tx_incr) tx_next = tx_next + 8'd1;
        pend_pop = bus.rx_valid && bus.rx_ready;
        pend_rx_byte = bus.rx_data;
        tx_idle_prev = !u_busy && !u_pend && tx_q.size() != 0;
        @(posedge sys_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset asserted between edges must clear the outputs without a clock.
    task automatic mid_reset();
        #2;
        sys_rst = 1'b1;
        #1;
        chk("rst_tx_level", bus.tx_level, 0);
        chk("rst_uart_wr", bus.uart_wr, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_level", bus.rx_level, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);
        clear_model();
        @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;
    endtask

    initial begin
        clear_model();
        tx_incr = 0; tx_next = 8'h00;
        p_tx = 0; p_rx = 0; p_arr = 0; frame_min = 2; frame_max = 4;
        #1;
        chk("init_tx_ready", bus.tx_ready, 1);
        chk("init_rx_valid", bus.rx_valid, 0);
        chk("init_tx_level", bus.tx_level, 0);
        chk("init_rx_level", bus.rx_level, 0);
        chk("init_uart_wr", bus.uart_wr, 0);
        chk("init_uart_rd", bus.uart_rd, 0);
        chk("init_out_data", bus.uart_out_data, 0);
        repeat (3) @(posedge sys_clk);
        #2;
        sys_rst = 1'b0;

        // Single byte 0xA5 into an idle bridge.
        run(5);
        tx_incr = 1; tx_next = 8'hA5; p_tx = 100; frame_min = 10; frame_max = 10;
        run(1);
        p_tx = 0;
        run(30);

        // Random mix on both paths.
        tx_incr = 0; p_tx = 40; p_rx = 50; p_arr = 40; frame_min = 2; frame_max = 12;
        run(600);

        // TX burst of incrementing bytes against slow frames.
        tx_incr = 1; tx_next = 8'h00; p_tx = 100; p_rx = 50; p_arr = 0;
        frame_min = 8; frame_max = 16;
        run(80);
        p_tx = 0;
        run(300);

        // RX back-pressure until full, then slow draining.
        tx_incr = 0; p_rx = 0; p_arr = 100;
        run(60);
        p_rx = 30;
        run(200);

        // TX saturated with short frames: push-at-full coincides with pops, pointers wrap.
        tx_incr = 1; p_tx = 100; p_rx = 60; p_arr = 50; frame_min = 1; frame_max = 3;
        run(200);

        // Asynchronous reset while a frame is in flight and bytes are queued.
        frame_min = 30; frame_max = 30; p_tx = 100;
        run(12);
        mid_reset();
        tx_incr = 0; p_tx = 20; p_rx = 50; p_arr = 30; frame_min = 2; frame_max = 8;
        run(200);

        // Drain everything.
        p_tx = 0; p_arr = 0; p_rx = 100;
        run(300);
        chk("drain_tx_level", bus.tx_level, 0);
        chk("drain_rx_level", bus.rx_level, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Buffering stage between the host logic and the byte-level UART core.
- The TX path queues host bytes in a FIFO and feeds them to the UART load interface (uart_out_data, uart_wr, uart_tx_empty) one frame at a time.
- The RX path drains received bytes from the UART (uart_in_data, uart_rd, uart_rx_empty) into a second FIFO, which the host reads with a valid/ready handshake.
- The host never handles UART timing or overrun.

Parameters:
- DEPTH_LOG2, 4: log2 of each FIFO depth (16 entries). Both FIFOs are the same size.

Ports:
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  reset, asynchronous and active-high.
- tx_data  in  8  host byte to transmit.
- tx_valid  in  1  host offers tx_data.
- tx_ready  out  1  TX FIFO not full; a byte is accepted when tx_valid & tx_ready.
- rx_data  out  8  head of the RX FIFO (first-word fall-through).
- rx_valid  out  1  RX FIFO not empty.
- rx_ready  in  1  host consumes rx_data when rx_valid & rx_ready.
- tx_level  out  DEPTH_LOG2+1  TX FIFO occupancy.
- rx_level  out  DEPTH_LOG2+1  RX FIFO occupancy.
- uart_out_data  out  8  byte presented to the UART; registered.
- uart_wr  out  1  one-cycle load strobe to the UART; registered.
- uart_tx_empty  in  1  UART transmitter idle.
- uart_in_data  in  8  UART received byte.
- uart_rd  out  1  one-cycle take strobe to the UART; registered.
- uart_rx_empty  in  1  UART holds no unread byte.

Behaviour:
- Reset values (asynchronous, while sys_rst=1):
  - uart_wr=0, uart_rd=0, uart_out_data=0.
  - Both FIFOs empty: tx_ready=1, rx_valid=0, tx_level=0, rx_level=0. rx_data is don't-care.
  - TX FSM in IDLE; rd_guard=0.
- Reset mid-frame: FIFO contents are discarded. The UART resets separately on its own reset.
- FIFOs:
  - Circular buffers with DEPTH_LOG2-bit read/write pointers; pointers wrap from 2^DEPTH_LOG2-1 to 0.
  - Level counter is DEPTH_LOG2+1 bits.
  - Simultaneous push and pop: level unchanged, both pointers advance. This is allowed when full for TX and when full for RX.
  - Push when full is ignored; tx_ready=0 guarantees the host never does this.
  - Pop when empty is ignored.
- TX FSM (states IDLE, ARM, BUSY):
  - IDLE: if TX FIFO not empty and uart_tx_empty=1, then:
    - register the head byte into uart_out_data;
    - set uart_wr=1;
    - pop the FIFO;
    - go to ARM.
  - ARM: uart_wr<=0; go to BUSY unconditionally. uart_tx_empty is ignored in this cycle because the UART updates its flag one cycle after the load.
  - BUSY: wait until uart_tx_empty=1, then go to IDLE.
  - uart_wr is high for exactly one cycle per byte.
  - Latency: a byte pushed at edge N into an empty FIFO with the UART idle gives uart_wr=1 after edge N+1.
  - Inter-frame gap: uart_wr reasserts one cycle after uart_tx_empty is first seen high in BUSY (IDLE takes one cycle).
- RX path:
  - When uart_rx_empty=0, rd_guard=0 and the RX FIFO is not full (or is being popped in the same cycle):
    - push uart_in_data;
    - set uart_rd=1 for one cycle;
    - set rd_guard=1.
  - The cycle after uart_rd, rd_guard blocks a second capture while the UART flag clears. rd_guard then returns to 0.
  - If the RX FIFO is full, the byte is left in the UART. A following UART byte then sets the UART's own overrun flag; the bridge does not drop bytes itself.
- Data ordering: strictly FIFO on both paths, with no reordering or duplication.

Test Plan:
- Reset, then a single byte: push 0xA5 at cycle 10 with the UART idle → uart_wr=1 at cycle 11 with uart_out_data=0xA5. With the 864-clock/bit UART, the line carries start bit, LSB-first 0xA5, stop bit. uart_tx_empty returns high 8640 cycles later. tx_level goes 1→0.
- TX burst to full: push 0x00..0x10 back-to-back (17 offers). The first byte is popped at once, so 16 remain queued and all 17 are accepted with tx_ready low only while level=16. Exactly 17 uart_wr pulses in order 0x00..0x10, each spaced one frame plus 2 cycles.
- RX capture: the UART model asserts uart_rx_empty=0 with uart_in_data=0x3C → uart_rd one cycle later, rx_valid=1, rx_data=0x3C. rx_ready=1 → rx_valid=0, rx_level=0.
- RX full back-pressure: hold rx_ready=0 and feed 17 bytes → rx_level=16, no uart_rd for the 17th byte. Raise rx_ready for one cycle → one pop, then uart_rd captures the 17th byte. Order is preserved.
- Simultaneous push/pop at full: TX level=16; the FSM pops in the same cycle the host pushes → tx_level stays 16 and no byte is lost. The pointers wrap, checked by reading back 20 bytes in order.
- Asynchronous reset mid-frame: assert sys_rst between clock edges during BUSY with tx_level=5 → tx_level=0, uart_wr=0, rx_valid=0 immediately. After release the FSM is in IDLE, and a new push transmits normally.
